// File: rtl/lsu_stb_ctlq_if.sv
// Store-buffer control queue port bundle: M/W-stage allocation from the store
// pipeline, drain/flush controls, and the per-entry state seen by PCX issue.
interface lsu_stb_ctlq_if #(
   parameter int ENTRIES = 8,
   parameter int PTR_W   = 3,
   parameter int FLD_W   = 5
);
   logic                     alloc_m;
   logic [FLD_W-1:0]         alloc_din_m;
   logic                     alloc_ack_m;
   logic [PTR_W-1:0]         alloc_ptr;
   logic                     kill_w;
   logic                     deq;
   logic                     flush;
   logic [ENTRIES-1:0]       ent_vld;
   logic [ENTRIES-1:0]       ent_pend;
   logic [ENTRIES*FLD_W-1:0] ent_data;
   logic [PTR_W-1:0]         head_ptr;
   logic                     head_vld;
   logic [FLD_W-1:0]         head_data;
   logic [PTR_W:0]           count;
   logic                     full;
   logic                     empty;

   // Handshake: alloc_m is a request qualified in the same cycle by
   // alloc_ack_m; a store is accepted exactly when both are high at the edge.
   // kill_w applies to the store accepted one cycle earlier. deq takes effect
   // only while head_vld is high. flush overrides everything in its cycle.
   modport master (
      output alloc_m, alloc_din_m, kill_w, deq, flush,
      input  alloc_ack_m, alloc_ptr, ent_vld, ent_pend, ent_data,
             head_ptr, head_vld, head_data, count, full, empty
   );

   modport slave (
      input  alloc_m, alloc_din_m, kill_w, deq, flush,
      output alloc_ack_m, alloc_ptr, ent_vld, ent_pend, ent_data,
             head_ptr, head_vld, head_data, count, full, empty
   );
endinterface

// File: rtl/lsu_stb_ctlq.sv
// Store-buffer control queue: in-order per-entry control records with
// speculative allocation in M, kill in W, head drain, flush and occupancy.
module lsu_stb_ctlq #(
   parameter int ENTRIES = 8,
   parameter int PTR_W   = 3,
   parameter int FLD_W   = 5
) (
   input  logic          rclk,
   input  logic          rst,
   lsu_stb_ctlq_if.slave stb
);

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(ENTRIES);

   logic [PTR_W-1:0]   wptr_q, wptr_d;
   logic [PTR_W-1:0]   rptr_q, rptr_d;
   logic [ENTRIES-1:0] vld_q, vld_d;
   logic [ENTRIES-1:0] pend_q, pend_d;
   logic [PTR_W-1:0]   pend_idx_q, pend_idx_d;
   logic               pend_live_q, pend_live_d;
   logic [PTR_W:0]     count_q, count_d;
   logic [FLD_W-1:0]   data_q [ENTRIES];

   logic                     full_w;
   logic                     empty_w;
   logic                     head_vld_w;
   logic                     ack_w;
   logic                     kill_eff_w;
   logic                     commit_w;
   logic                     deq_eff_w;
   logic [ENTRIES*FLD_W-1:0] ent_flat_w;

   always_comb begin
      full_w     = (count_q == CNT_FULL);
      empty_w    = (count_q == '0);
      head_vld_w = vld_q[rptr_q];
      // full is registered, so a same-cycle dequeue never frees a slot early.
      ack_w      = stb.alloc_m & ~full_w & ~stb.kill_w & ~stb.flush;
      kill_eff_w = pend_live_q & stb.kill_w & ~stb.flush;
      commit_w   = pend_live_q & ~stb.kill_w & ~stb.flush;
      deq_eff_w  = stb.deq & head_vld_w & ~stb.flush;
   end

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      vld_d       = vld_q;
      pend_d      = pend_q;
      pend_idx_d  = pend_idx_q;
      pend_live_d = pend_live_q;
      count_d     = count_q;

      if (stb.flush) begin
         wptr_d      = '0;
         rptr_d      = '0;
         vld_d       = '0;
         pend_d      = '0;
         pend_live_d = 1'b0;
         count_d     = '0;
      end else begin
         // W-stage resolution of last cycle's allocation.
         if (pend_live_q) begin
            pend_d[pend_idx_q] = 1'b0;
         end
         if (commit_w) begin
            vld_d[pend_idx_q] = 1'b1;
         end
         pend_live_d = ack_w;

         // ack is gated by kill_w, so these two never coincide.
         if (ack_w) begin
            pend_d[wptr_q] = 1'b1;
            pend_idx_d     = wptr_q;
            wptr_d         = wptr_q + PTR_ONE;
            count_d        = count_d + CNT_ONE;
         end else if (kill_eff_w) begin
            wptr_d  = wptr_q - PTR_ONE;
            count_d = count_d - CNT_ONE;
         end

         if (deq_eff_w) begin
            vld_d[rptr_q] = 1'b0;
            rptr_d        = rptr_q + PTR_ONE;
            count_d       = count_d - CNT_ONE;
         end
      end
   end

   always_ff @(posedge rclk or posedge rst) begin
      if (rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         vld_q       <= '0;
         pend_q      <= '0;
         pend_idx_q  <= '0;
         pend_live_q <= 1'b0;
         count_q     <= '0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         vld_q       <= vld_d;
         pend_q      <= pend_d;
         pend_idx_q  <= pend_idx_d;
         pend_live_q <= pend_live_d;
         count_q     <= count_d;
      end
   end

   // Killed entries keep stale fields; flush keeps all fields.
   always_ff @(posedge rclk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            data_q[i] <= '0;
         end
      end else if (ack_w) begin
         data_q[wptr_q] <= stb.alloc_din_m;
      end
   end

   always_comb begin
      ent_flat_w = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         ent_flat_w[i*FLD_W +: FLD_W] = data_q[i];
      end
   end

   assign stb.alloc_ack_m = ack_w;
   assign stb.alloc_ptr   = wptr_q;
   assign stb.ent_vld     = vld_q;
   assign stb.ent_pend    = pend_q;
   assign stb.ent_data    = ent_flat_w;
   assign stb.head_ptr    = rptr_q;
   assign stb.head_vld    = head_vld_w;
   assign stb.head_data   = data_q[rptr_q];
   assign stb.count       = count_q;
   assign stb.full        = full_w;
   assign stb.empty       = empty_w;

endmodule

// File: tb/tb_lsu_stb_ctlq.sv
// Directed bench for lsu_stb_ctlq: fill/wrap, kill, full+deq, pending-head
// deq, flush priority and asynchronous reset, with hand-computed expectations.
module tb_lsu_stb_ctlq;
   localparam int ENTRIES = 8;
   localparam int PTR_W   = 3;
   localparam int FLD_W   = 5;

   logic rclk;
   logic rst;
   int   total;
   int   bad;
   logic [ENTRIES*FLD_W-1:0] exp_data;

   lsu_stb_ctlq_if #(.ENTRIES(ENTRIES), .PTR_W(PTR_W), .FLD_W(FLD_W)) ifc ();

   lsu_stb_ctlq #(.ENTRIES(ENTRIES), .PTR_W(PTR_W), .FLD_W(FLD_W)) dut (
      .rclk (rclk),
      .rst  (rst),
      .stb  (ifc.slave)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_ent(input int idx, input logic [FLD_W-1:0] val);
      exp_data[idx*FLD_W +: FLD_W] = val;
   endtask

   task automatic alloc(input logic [FLD_W-1:0] din, input logic exp_ack, input string tag);
      ifc.alloc_m     = 1'b1;
      ifc.alloc_din_m = din;
      #1;
      chk(tag, 64'(ifc.alloc_ack_m), 64'(exp_ack));
      tick();
      ifc.alloc_m = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      exp_data = '0;
      rst             = 1'b1;
      ifc.alloc_m     = 1'b0;
      ifc.alloc_din_m = '0;
      ifc.kill_w      = 1'b0;
      ifc.deq         = 1'b0;
      ifc.flush       = 1'b0;
      tick();
      tick();

      // reset state
      chk("rst_count", 64'(ifc.count), 64'd0);
      chk("rst_empty", 64'(ifc.empty), 64'd1);
      chk("rst_full", 64'(ifc.full), 64'd0);
      chk("rst_ack", 64'(ifc.alloc_ack_m), 64'd0);
      chk("rst_head_vld", 64'(ifc.head_vld), 64'd0);
      chk("rst_data", 64'(ifc.ent_data), 64'd0);
      rst = 1'b0;
      tick();

      // fill 8 entries back to back
      for (int i = 0; i < ENTRIES; i++) begin
         alloc(FLD_W'(i), 1'b1, "fill_ack");
         set_ent(i, FLD_W'(i));
      end
      chk("fill_full_pre", 64'(ifc.full), 64'd1);
      alloc(5'h1E, 1'b0, "ninth_ack");
      chk("fill_vld", 64'(ifc.ent_vld), 64'hFF);
      chk("fill_pend", 64'(ifc.ent_pend), 64'h00);
      chk("fill_count", 64'(ifc.count), 64'd8);
      chk("fill_full", 64'(ifc.full), 64'd1);
      chk("fill_data", 64'(ifc.ent_data), 64'(exp_data));
      chk("fill_aptr", 64'(ifc.alloc_ptr), 64'd0);

      // drain 3 then wrap-allocate 3
      ifc.deq = 1'b1;
      tick(); tick(); tick();
      ifc.deq = 1'b0;
      chk("deq3_head", 64'(ifc.head_ptr), 64'd3);
      chk("deq3_vld", 64'(ifc.ent_vld), 64'hF8);
      chk("deq3_count", 64'(ifc.count), 64'd5);
      for (int i = 0; i < 3; i++) begin
         alloc(FLD_W'(5'h10 + i), 1'b1, "wrap_ack");
         set_ent(i, FLD_W'(5'h10 + i));
      end
      tick();
      chk("wrap_aptr", 64'(ifc.alloc_ptr), 64'd3);
      chk("wrap_head", 64'(ifc.head_ptr), 64'd3);
      chk("wrap_count", 64'(ifc.count), 64'd8);
      chk("wrap_vld", 64'(ifc.ent_vld), 64'hFF);
      chk("wrap_head_data", 64'(ifc.head_data), 64'h03);
      chk("wrap_data", 64'(ifc.ent_data), 64'(exp_data));

      // full: alloc and deq in the same cycle, alloc refused
      ifc.deq = 1'b1;
      alloc(5'h1F, 1'b0, "full_deq_ack");
      ifc.deq = 1'b0;
      chk("full_deq_count", 64'(ifc.count), 64'd7);
      chk("full_deq_vld", 64'(ifc.ent_vld), 64'hF7);
      alloc(5'h1F, 1'b1, "refill_ack");
      set_ent(3, 5'h1F);
      chk("refill_count", 64'(ifc.count), 64'd8);
      chk("refill_pend", 64'(ifc.ent_pend), 64'h08);
      tick();
      chk("refill_vld", 64'(ifc.ent_vld), 64'hFF);
      chk("refill_data", 64'(ifc.ent_data), 64'(exp_data));

      // flush with 5 valid + 1 pending, kill/deq/alloc also asserted
      ifc.deq = 1'b1;
      tick(); tick(); tick();
      ifc.deq = 1'b0;
      chk("pre_flush_vld", 64'(ifc.ent_vld), 64'h8F);
      alloc(5'h0A, 1'b1, "pre_flush_ack");
      set_ent(4, 5'h0A);
      chk("pre_flush_pend", 64'(ifc.ent_pend), 64'h10);
      chk("pre_flush_count", 64'(ifc.count), 64'd6);
      ifc.flush  = 1'b1;
      ifc.kill_w = 1'b1;
      ifc.deq    = 1'b1;
      alloc(5'h01, 1'b0, "flush_ack");
      ifc.flush  = 1'b0;
      ifc.kill_w = 1'b0;
      ifc.deq    = 1'b0;
      chk("flush_vld", 64'(ifc.ent_vld), 64'h00);
      chk("flush_pend", 64'(ifc.ent_pend), 64'h00);
      chk("flush_count", 64'(ifc.count), 64'd0);
      chk("flush_head", 64'(ifc.head_ptr), 64'd0);
      chk("flush_aptr", 64'(ifc.alloc_ptr), 64'd0);
      chk("flush_empty", 64'(ifc.empty), 64'd1);
      chk("flush_data_kept", 64'(ifc.ent_data), 64'(exp_data));
      chk("flush_head_data", 64'(ifc.head_data), 64'h10);

      // kill of the store allocated at entry 3
      alloc(5'h01, 1'b1, "k_ack0"); set_ent(0, 5'h01);
      alloc(5'h02, 1'b1, "k_ack1"); set_ent(1, 5'h02);
      alloc(5'h03, 1'b1, "k_ack2"); set_ent(2, 5'h03);
      alloc(5'h15, 1'b1, "k_ack3"); set_ent(3, 5'h15);
      chk("k_pend", 64'(ifc.ent_pend), 64'h08);
      chk("k_aptr_pre", 64'(ifc.alloc_ptr), 64'd4);
      chk("k_count_pre", 64'(ifc.count), 64'd4);
      ifc.kill_w = 1'b1;
      alloc(5'h1C, 1'b0, "kill_cycle_ack");
      ifc.kill_w = 1'b0;
      chk("kill_pend", 64'(ifc.ent_pend), 64'h00);
      chk("kill_vld", 64'(ifc.ent_vld), 64'h07);
      chk("kill_aptr", 64'(ifc.alloc_ptr), 64'd3);
      chk("kill_count", 64'(ifc.count), 64'd3);
      alloc(5'h06, 1'b1, "reuse_ack");
      set_ent(3, 5'h06);
      chk("reuse_aptr", 64'(ifc.alloc_ptr), 64'd4);
      tick();
      chk("reuse_vld", 64'(ifc.ent_vld), 64'h0F);
      chk("reuse_count", 64'(ifc.count), 64'd4);
      chk("reuse_data", 64'(ifc.ent_data), 64'(exp_data));

      // kill at wptr=0 wraps back to 7
      ifc.deq = 1'b1;
      tick(); tick(); tick(); tick();
      ifc.deq = 1'b0;
      chk("drain_empty", 64'(ifc.empty), 64'd1);
      chk("drain_head", 64'(ifc.head_ptr), 64'd4);
      for (int i = 4; i < ENTRIES; i++) begin
         alloc(FLD_W'(5'h10 + i), 1'b1, "wk_ack");
      end
      chk("wk_aptr_pre", 64'(ifc.alloc_ptr), 64'd0);
      chk("wk_pend_pre", 64'(ifc.ent_pend), 64'h80);
      ifc.kill_w = 1'b1;
      tick();
      ifc.kill_w = 1'b0;
      chk("wk_aptr", 64'(ifc.alloc_ptr), 64'd7);
      chk("wk_count", 64'(ifc.count), 64'd3);
      chk("wk_vld", 64'(ifc.ent_vld), 64'h70);
      chk("wk_pend", 64'(ifc.ent_pend), 64'h00);

      // deq while head is still pending is ignored
      ifc.flush = 1'b1;
      tick();
      ifc.flush = 1'b0;
      alloc(5'h07, 1'b1, "ph_ack");
      chk("ph_head_vld_pre", 64'(ifc.head_vld), 64'd0);
      ifc.deq = 1'b1;
      tick();
      chk("ph_head_vld", 64'(ifc.head_vld), 64'd1);
      chk("ph_count", 64'(ifc.count), 64'd1);
      chk("ph_head", 64'(ifc.head_ptr), 64'd0);
      chk("ph_head_data", 64'(ifc.head_data), 64'h07);
      tick();
      ifc.deq = 1'b0;
      chk("ph_count_after", 64'(ifc.count), 64'd0);
      chk("ph_empty", 64'(ifc.empty), 64'd1);
      chk("ph_head_after", 64'(ifc.head_ptr), 64'd1);
      chk("ph_head_vld_after", 64'(ifc.head_vld), 64'd0);

      // asynchronous reset mid-allocation, checked before the next edge
      ifc.alloc_m     = 1'b1;
      ifc.alloc_din_m = 5'h09;
      tick();
      tick();
      chk("ar_count_pre", 64'(ifc.count), 64'd2);
      rst = 1'b1;
      #1;
      chk("ar_count", 64'(ifc.count), 64'd0);
      chk("ar_vld", 64'(ifc.ent_vld), 64'h00);
      chk("ar_pend", 64'(ifc.ent_pend), 64'h00);
      chk("ar_aptr", 64'(ifc.alloc_ptr), 64'd0);
      chk("ar_head", 64'(ifc.head_ptr), 64'd0);
      chk("ar_data", 64'(ifc.ent_data), 64'd0);
      chk("ar_empty", 64'(ifc.empty), 64'd1);
      ifc.alloc_m = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      alloc(5'h0B, 1'b1, "post_rst_ack");
      chk("post_rst_pend", 64'(ifc.ent_pend), 64'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
